// File: rtl/idac_ctrl_mc.sv
// idac_ctrl_mc: multi-channel current-DAC update controller.
// A trigger sampled in IDLE registers new enables, current codes and
// calibration codes for every channel. Current codes are either loaded
// directly or moved one saturating step towards the target. A settle
// counter then holds the block busy until data-ready is pulsed.
// Handshake: trigger_i is a level request and is accepted on any rising
// edge where the FSM is IDLE. busy_o is high while a previous update
// settles. dr_o marks the cycle in which the update is complete.
// A new rising edge of trigger_i seen while busy is dropped and recorded
// in overrun_o.
module idac_ctrl_mc #(
    parameter int NumChannels       = 2,
    parameter int CurrentWidth      = 8,
    parameter int CalibrationWidth  = 5,
    parameter int Trigger2DrDelayCc = 3
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumChannels-1:0]                 en_i,
    input  logic                                   mode_i,
    input  logic [NumChannels*CurrentWidth-1:0]     cur_i,
    input  logic [NumChannels*CalibrationWidth-1:0] cal_i,
    input  logic [CurrentWidth-1:0]                step_i,
    input  logic                                   trigger_i,
    output logic                                   busy_o,
    output logic                                   dr_o,
    output logic                                   overrun_o,
    output logic [NumChannels-1:0]                 idac_en_o,
    output logic [NumChannels*CurrentWidth-1:0]     idac_cur_o,
    output logic [NumChannels*CalibrationWidth-1:0] idac_cal_o
);

    localparam int CW  = CurrentWidth;
    localparam int CLW = CalibrationWidth;
    localparam logic [7:0] DelayLoad = 8'(Trigger2DrDelayCc - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [7:0] cnt_q;
    logic       trig_q;
    logic       accept;
    logic       expire;

    logic [NumChannels*CW-1:0]  nxt_cur;
    logic [NumChannels*CLW-1:0] nxt_cal;
    logic [CW:0]                c_x, g_x, s_x, sum_x, dif_x;

    assign accept = (state_q == IDLE) && trigger_i;
    assign expire = (state_q == SETTLE) && (cnt_q == 8'd1);
    assign busy_o = (state_q == SETTLE);

    // Next-state logic: a delay of one cycle never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger_i && (Trigger2DrDelayCc > 1)) state_d = SETTLE;
            SETTLE:  if (cnt_q == 8'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Settle counter: loaded on accept, counts down to the expiry value 1.
    always_ff @(posedge clk_i) begin
        if (rst_i)                    cnt_q <= 8'd0;
        else if (accept)              cnt_q <= DelayLoad;
        else if (state_q == SETTLE)   cnt_q <= cnt_q - 8'd1;
    end

    // Data-ready pulse and trigger history for overrun edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dr_o   <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            dr_o   <= (accept && (Trigger2DrDelayCc == 1)) || expire;
            trig_q <= trigger_i;
        end
    end

    // Sticky overrun: a fresh request while busy; cleared by the next accept.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                   overrun_o <= 1'b0;
        else if (accept)                             overrun_o <= 1'b0;
        else if (busy_o && trigger_i && !trig_q)     overrun_o <= 1'b1;
    end

    // Per-channel next codes: direct load or saturating ramp step in CW+1 bits.
    always_comb begin
        nxt_cur = '0;
        nxt_cal = '0;
        c_x     = '0;
        g_x     = '0;
        s_x     = '0;
        sum_x   = '0;
        dif_x   = '0;
        for (int k = 0; k < NumChannels; k++) begin
            c_x   = {1'b0, (idac_en_o[k] ? idac_cur_o[k*CW +: CW] : {CW{1'b0}})};
            g_x   = {1'b0, cur_i[k*CW +: CW]};
            s_x   = {1'b0, step_i};
            sum_x = c_x + s_x;
            dif_x = c_x - s_x;
            if (en_i[k]) begin
                nxt_cal[k*CLW +: CLW] = cal_i[k*CLW +: CLW];
                if (!mode_i) begin
                    nxt_cur[k*CW +: CW] = g_x[CW-1:0];
                end else if (g_x > c_x) begin
                    nxt_cur[k*CW +: CW] = (sum_x > g_x) ? g_x[CW-1:0] : sum_x[CW-1:0];
                end else if (g_x < c_x) begin
                    nxt_cur[k*CW +: CW] = (dif_x[CW] || (dif_x < g_x)) ? g_x[CW-1:0]
                                                                      : dif_x[CW-1:0];
                end else begin
                    nxt_cur[k*CW +: CW] = c_x[CW-1:0];
                end
            end
        end
    end

    // Output registers to the analog macro, updated only on an accepted trigger.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idac_en_o  <= '0;
            idac_cur_o <= '0;
            idac_cal_o <= '0;
        end else if (accept) begin
            idac_en_o  <= en_i;
            idac_cur_o <= nxt_cur;
            idac_cal_o <= nxt_cal;
        end
    end

endmodule

// File: tb/tb_idac_ctrl_mc.sv
// Directed bench for idac_ctrl_mc: default instance (delay 3) plus a
// delay-1 instance sharing the same stimulus.
module tb_idac_ctrl_mc;

    localparam int N   = 2;
    localparam int CW  = 8;
    localparam int CLW = 5;
    localparam int D   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      en;
    logic              mode;
    logic [N*CW-1:0]   cur;
    logic [N*CLW-1:0]  cal;
    logic [CW-1:0]     stp;
    logic              trig;

    logic              busy, dr, ovr;
    logic [N-1:0]      ien;
    logic [N*CW-1:0]   icur;
    logic [N*CLW-1:0]  ical;
    logic              busy1, dr1, ovr1;
    logic [N-1:0]      ien1;
    logic [N*CW-1:0]   icur1;
    logic [N*CLW-1:0]  ical1;

    int n_cmp = 0;
    int n_err = 0;

    // Clock
    always #5 clk = ~clk;

    idac_ctrl_mc #(.NumChannels(N), .CurrentWidth(CW), .CalibrationWidth(CLW),
                   .Trigger2DrDelayCc(D)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .cur_i(cur),
        .cal_i(cal), .step_i(stp), .trigger_i(trig), .busy_o(busy),
        .dr_o(dr), .overrun_o(ovr), .idac_en_o(ien), .idac_cur_o(icur),
        .idac_cal_o(ical));

    idac_ctrl_mc #(.NumChannels(N), .CurrentWidth(CW), .CalibrationWidth(CLW),
                   .Trigger2DrDelayCc(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .cur_i(cur),
        .cal_i(cal), .step_i(stp), .trigger_i(trig), .busy_o(busy1),
        .dr_o(dr1), .overrun_o(ovr1), .idac_en_o(ien1), .idac_cur_o(icur1),
        .idac_cal_o(ical1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted update, returning in the cycle dr_o is expected high.
    task automatic fire(input logic [N-1:0] e, input logic m, input logic [N*CW-1:0] c,
                        input logic [N*CLW-1:0] k, input logic [CW-1:0] s);
        en = e; mode = m; cur = c; cal = k; stp = s; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (D - 1) tick();
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = 1'b0; cur = '0; cal = '0; stp = '0; trig = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dr", 32'(dr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_en", 32'(ien), 32'd0);
        chk("rst_cur", 32'(icur), 32'd0);
        chk("rst_cal", 32'(ical), 32'd0);

        // Direct load, timing of busy and dr
        en = 2'b11; mode = 1'b0; cur = {8'h40, 8'hC0}; cal = {5'd3, 5'd17}; trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("dir_cur", 32'(icur), 32'h40C0);
        chk("dir_cal", 32'(ical), 32'({5'd3, 5'd17}));
        chk("dir_en", 32'(ien), 32'h3);
        chk("dir_busy_c1", 32'(busy), 32'd1);
        chk("dir_dr_c1", 32'(dr), 32'd0);
        chk("d1_dr", 32'(dr1), 32'd1);
        chk("d1_busy", 32'(busy1), 32'd0);
        chk("d1_cur", 32'(icur1), 32'h40C0);
        tick();
        chk("dir_busy_c2", 32'(busy), 32'd1);
        chk("dir_dr_c2", 32'(dr), 32'd0);
        chk("d1_dr_off", 32'(dr1), 32'd0);
        tick();
        chk("dir_busy_c3", 32'(busy), 32'd0);
        chk("dir_dr_c3", 32'(dr), 32'd1);
        tick();
        chk("dir_dr_c4", 32'(dr), 32'd0);

        // Ramp saturation at both ends
        fire(2'b11, 1'b0, {8'h10, 8'hF0}, {5'd3, 5'd17}, 8'h00);
        chk("pre_ramp_cur", 32'(icur), 32'h10F0);
        chk("pre_ramp_dr", 32'(dr), 32'd1);
        fire(2'b11, 1'b1, {8'h00, 8'hFF}, {5'd9, 5'd1}, 8'h20);
        chk("ramp_sat_cur", 32'(icur), 32'h00FF);
        chk("ramp_cal", 32'(ical), 32'({5'd9, 5'd1}));
        fire(2'b11, 1'b1, {8'h50, 8'h00}, {5'd9, 5'd1}, 8'h30);
        chk("ramp_step_cur", 32'(icur), 32'h30CF);
        fire(2'b11, 1'b1, {8'hFF, 8'h00}, {5'd9, 5'd1}, 8'h00);
        chk("ramp_zero_cur", 32'(icur), 32'h30CF);
        chk("ramp_zero_dr", 32'(dr), 32'd1);

        // Disable channel 1, then ramp it up from 0
        fire(2'b01, 1'b0, 16'h1234, {5'd7, 5'd21}, 8'h00);
        chk("dis_en", 32'(ien), 32'h1);
        chk("dis_cur", 32'(icur), 32'h0034);
        chk("dis_cal", 32'(ical), 32'({5'd0, 5'd21}));
        fire(2'b11, 1'b1, {8'h50, 8'h34}, {5'd7, 5'd21}, 8'h20);
        chk("reen_cur", 32'(icur), 32'h2034);

        // Trigger held high: back-to-back updates every D cycles
        en = 2'b11; mode = 1'b0; cur = 16'hAAAA; trig = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("hold_dr", 32'(dr), 32'((i % 3) == 0));
            chk("hold_busy", 32'(busy), 32'((i % 3) != 0));
            chk("hold_ovr", 32'(ovr), 32'd0);
        end
        trig = 1'b0;
        tick(); tick();
        chk("hold_last_dr", 32'(dr), 32'd1);

        // Second trigger while busy is dropped and flagged
        cur = 16'h1111; trig = 1'b1;
        tick();
        trig = 1'b0; cur = 16'h2222;
        tick();
        chk("ovr_busy", 32'(busy), 32'd1);
        chk("ovr_pre", 32'(ovr), 32'd0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_dr", 32'(dr), 32'd1);
        chk("ovr_cur_kept", 32'(icur), 32'h1111);
        tick();
        chk("ovr_sticky", 32'(ovr), 32'd1);
        chk("ovr_dr_off", 32'(dr), 32'd0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'd0);
        chk("ovr_new_cur", 32'(icur), 32'h2222);
        tick(); tick();
        chk("ovr_new_dr", 32'(dr), 32'd1);

        // Reset one cycle after trigger aborts the update
        cur = 16'h5555; trig = 1'b1;
        tick();
        trig = 1'b0; rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dr", 32'(dr), 32'd0);
        chk("abort_en", 32'(ien), 32'd0);
        chk("abort_cur", 32'(icur), 32'd0);
        chk("abort_cal", 32'(ical), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_dr", 32'(dr), 32'd0);
        end

        // Reset and trigger together: reset wins
        rst = 1'b1; trig = 1'b1;
        tick();
        chk("rst_trig_cur", 32'(icur), 32'd0);
        chk("rst_trig_busy", 32'(busy), 32'd0);
        rst = 1'b0; trig = 1'b0;
        tick();
        chk("rst_trig_cur2", 32'(icur), 32'd0);
        chk("rst_trig_busy2", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
